// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported unified memory between the fetch stage (IF) and
// the memory stage (ME). ME has fixed priority over IF. Each bus transaction
// uses a req/ack handshake. The arbiter also places sub-word store data on
// the correct byte lanes and extracts and extends sub-word load results.
//
// Handshake semantics (all requests and mem_req):
//   A requester raises its request and holds it, with its address and data
//   stable, until its one-cycle completion pulse arrives (if_valid or
//   me_done). On the bus, mem_req and every mem_* output stay constant until
//   a rising edge samples mem_ack=1. mem_ack is ignored while mem_req=0.
//
// Ports:
//   clk, rst (asynchronous, active-low)
//   if_req/if_addr      -> if_rdata/if_valid          fetch side
//   me_read/me_write/me_addr/me_wdata/me_length/me_sign
//                       -> me_rdata/me_done/misalign_err   load/store side
//   stall_if, stall_pipe                              pipeline hold controls
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be <- mem_ack/mem_rdata   memory bus
//   dbg_state                                         current FSM state
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                me_read,
  input  logic                me_write,
  input  logic [ADDR_W-1:0]   me_addr,
  input  logic [DATA_W-1:0]   me_wdata,
  input  logic [1:0]          me_length,
  input  logic                me_sign,
  output logic [DATA_W-1:0]   me_rdata,
  output logic                me_done,
  output logic                misalign_err,
  output logic                stall_if,
  output logic                stall_pipe,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ME_BUS = 2'd1,
    IF_BUS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state;
  logic                me_pend;
  logic                me_misalign;
  logic [DATA_W/8-1:0] st_be;
  logic [DATA_W-1:0]   st_wdata;

  // Load shape captured at grant time so extraction does not depend on the
  // requester still holding its inputs when the ack arrives.
  logic [1:0]          ld_len;
  logic [1:0]          ld_off;
  logic                ld_sign;

  // Fetch addresses are word-aligned by construction; the low bits carry no
  // information.
  logic                if_addr_lsb_unused;
  assign if_addr_lsb_unused = ^if_addr[1:0];

  assign me_pend    = me_read | me_write;
  assign stall_pipe = me_pend & ~me_done;
  assign stall_if   = stall_pipe | (if_req & ~if_valid);
  assign dbg_state  = state;

  // Lane placement for stores and the alignment check for the ME access.
  always_comb begin
    me_misalign = 1'b0;
    st_be       = '0;
    st_wdata    = '0;
    case (me_length)
      2'b00: begin
        st_be    = 4'b0001 << me_addr[1:0];
        st_wdata = {4{me_wdata[7:0]}};
      end
      2'b01: begin
        st_be       = me_addr[1] ? 4'b1100 : 4'b0011;
        st_wdata    = {2{me_wdata[15:0]}};
        me_misalign = me_addr[0];
      end
      default: begin
        st_be       = 4'b1111;
        st_wdata    = me_wdata;
        me_misalign = |me_addr[1:0];
      end
    endcase
  end

  function automatic logic [31:0] load_extract(input logic [31:0] w,
                                               input logic [1:0]  len,
                                               input logic [1:0]  off,
                                               input logic        sgn);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (len)
      2'b00:   r = {{24{sgn & b[7]}}, b};
      2'b01:   r = {{16{sgn & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_be       <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      if_valid     <= 1'b0;
      me_done      <= 1'b0;
      misalign_err <= 1'b0;
      if_rdata     <= '0;
      me_rdata     <= '0;
      ld_len       <= 2'b00;
      ld_off       <= 2'b00;
      ld_sign      <= 1'b0;
    end else begin
      // Completion flags are single-cycle pulses.
      if_valid     <= 1'b0;
      me_done      <= 1'b0;
      misalign_err <= 1'b0;
      case (state)
        IDLE: begin
          if (me_pend) begin
            if (me_misalign) begin
              // Rejected without touching the bus.
              me_done      <= 1'b1;
              misalign_err <= 1'b1;
              me_rdata     <= '0;
              state        <= DONE;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= me_write;
              mem_addr  <= {me_addr[ADDR_W-1:2], 2'b00};
              mem_be    <= me_write ? st_be : '1;
              mem_wdata <= me_write ? st_wdata : '0;
              ld_len    <= me_length;
              ld_off    <= me_addr[1:0];
              ld_sign   <= me_sign;
              state     <= ME_BUS;
            end
          end else if (if_req) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= {if_addr[ADDR_W-1:2], 2'b00};
            mem_be    <= '1;
            mem_wdata <= '0;
            state     <= IF_BUS;
          end
        end
        ME_BUS: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            me_rdata <= mem_we ? '0 : load_extract(mem_rdata, ld_len, ld_off, ld_sign);
            me_done  <= 1'b1;
            state    <= DONE;
          end
        end
        IF_BUS: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            if_rdata <= mem_rdata;
            if_valid <= 1'b1;
            state    <= DONE;
          end
        end
        // One dead cycle so the request that just completed, still held by
        // its requester, is not granted a second time.
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares a single-ported unified instruction/data memory between the fetch stage (IF) and the memory stage (ME) of the RISC-V pipeline.
- Sequences each bus transaction with a req/ack handshake.
- Generates byte enables and lane-aligned write data for sub-word stores.
- Extracts and sign- or zero-extends sub-word loads.
- Drives the stall inputs of the fetch logic and of the pipeline registers (IF/ID, ID/EX, EX/ME).

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, memory data width (fixed at 32; 4 byte lanes)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset; asynchronous, active-low (0 = reset)
if_req  in  1  fetch request, held until if_valid
if_addr  in  ADDR_W  fetch address; bits [1:0] ignored
if_rdata  out  32  fetched instruction, valid while if_valid=1
if_valid  out  1  one-cycle fetch completion pulse
me_read  in  1  load request from EX/ME, held until me_done
me_write  in  1  store request from EX/ME, held until me_done
me_addr  in  ADDR_W  load/store byte address
me_wdata  in  32  store data, right-justified
me_length  in  2  00 byte, 01 half, 10/11 word
me_sign  in  1  1 = sign-extend load, 0 = zero-extend
me_rdata  out  32  extended load result, valid while me_done=1
me_done  out  1  one-cycle ME completion pulse
misalign_err  out  1  one-cycle pulse for a misaligned ME access
stall_if  out  1  hold the PC and IF/ID register
stall_pipe  out  1  hold ID/EX and EX/ME
mem_req  out  1  bus request
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  word-aligned address, [1:0]=00
mem_wdata  out  32  lane-replicated store data
mem_be  out  4  byte enables (bit i = lane i, bits [8i+7:8i])
mem_ack  in  1  transaction complete; sampled only while mem_req=1
mem_rdata  in  32  read data, valid in the cycle where mem_ack=1

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_valid, me_done, misalign_err, if_rdata and me_rdata are all 0. mem_req falls immediately, without waiting for clk.
- FSM states: IDLE, ME_BUS, IF_BUS, DONE.
- IDLE transitions:
  - ME pending (me_read|me_write):
    - Aligned access → ME_BUS; assert mem_req with address, we, be and wdata registered.
    - Misaligned access (half with addr[0]=1, or word with addr[1:0]≠0) → DONE with me_done=1, misalign_err=1, me_rdata=0; no bus cycle.
  - Else if_req → IF_BUS (mem_we=0, mem_be=1111).
  - ME has fixed priority over IF.
- ME_BUS / IF_BUS:
  - mem_req and all mem_* outputs are held stable until an edge samples mem_ack=1.
  - On that edge: mem_req←0; the selected result register loads; the matching done pulse (me_done or if_valid) asserts for exactly one cycle; next state = DONE.
  - Minimum latency: request seen in IDLE → mem_req next cycle → done one cycle after the ack edge.
- DONE: lasts one cycle and issues no new grant. This guarantees the held request that just completed is not re-issued. Next state = IDLE.
- In IDLE or DONE, mem_ack is ignored; a spurious or late ack is dropped.
- Store lanes by me_length:
  - byte: be = 0001<<addr[1:0], wdata = {4{wdata[7:0]}}
  - half: be = 0011<<(2*addr[1]), wdata = {2{wdata[15:0]}}
  - word: be = 1111, wdata = me_wdata
- Load lanes:
  - byte: lane addr[1:0]; bit 7 replicated if me_sign=1, else zero-filled.
  - half: bits [16*addr[1]+15 : 16*addr[1]], extended the same way.
  - word: passed through unchanged.
- Stalls (combinational):
  - stall_pipe = (me_read|me_write) & ~me_done
  - stall_if = stall_pipe | (if_req & ~if_valid)
- me_read and me_write both high: treated as a write.
- A request withdrawn while its transaction is on the bus does not abort the transaction. The bus cycle completes and the done pulse is still generated.

Test Plan:
1. Word load, me_addr=0x100, mem_ack two cycles after mem_req, mem_rdata=0xDEADBEEF → mem_addr=0x100, mem_we=0; me_done pulses 1 cycle with me_rdata=0xDEADBEEF; stall_pipe=1 from request until the me_done cycle.
2. Byte load at 0x103, mem_rdata=0x80000000: me_sign=1 → me_rdata=0xFFFFFF80; me_sign=0 → me_rdata=0x00000080.
3. Half store at 0x202, me_wdata=0x0000ABCD → mem_addr=0x200, mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, held until ack.
4. if_req and me_read raised in the same IDLE cycle → ME transaction first (stall_if=1); IF mem_req issued two cycles after me_done (DONE, then IDLE); if_valid pulses with the fetched word.
5. Word load at 0x102 → misalign_err and me_done pulse together for 1 cycle, me_rdata=0, mem_req never asserts.
6. rst driven low mid-clock while mem_req=1 awaiting ack → mem_req=0 immediately; after release state=IDLE; a late mem_ack produces no done pulse.
